match_controller: RTL

- Game-flow sequencer for the pong design. It sits between the ball object and the two-digit score displays.
- It takes per-player goal pulses and the start/pause button, and owns both scores.
- It gates ball motion through serve, play, pause and game-over phases, and requests ball re-centring before each serve.
- Score outputs feed the decimal display decoders directly; the ball and control outputs feed the ball object.

---
 rtl/match_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/match_controller.sv
// Pong game-flow sequencer: owns both scores, gates ball motion through
// serve/play/pause/over phases and requests ball re-centring before each serve.
module match_controller #(
    parameter int WinScore   = 11,
    parameter int ServeDelay = 60
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       Goal1,
    input  logic       Goal2,
    input  logic       Start,
    output logic [6:0] Score1,
    output logic [6:0] Score2,
    output logic       BallEnable,
    output logic       BallRecentre,
    output logic       ServeDir,
    output logic [1:0] Winner,
    output logic [2:0] State
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam logic [6:0] WIN_SCORE   = 7'(WinScore);
    localparam logic [7:0] SERVE_COUNT = 8'(ServeDelay);

    logic [2:0]      state_reg, state_next;
    logic [1:0][6:0] score_reg, score_next;
    logic [1:0][6:0] score_inc;
    logic [1:0]      score_hit;
    logic            enable_reg, enable_next;
    logic            recentre_reg, recentre_next;
    logic            dir_reg, dir_next;
    logic [1:0]      winner_reg, winner_next;
    logic [7:0]      count_reg, count_next;
    logic            start_q_reg;
    logic            start_edge;

    // Index 0 is player 1, index 1 is player 2; score_hit means this goal wins.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_player
            assign score_inc[gi] = score_reg[gi] + 7'd1;
            assign score_hit[gi] = (score_inc[gi] == WIN_SCORE);
        end
    endgenerate

    assign start_edge = Start & ~start_q_reg;

    always_comb begin
        state_next    = state_reg;
        score_next    = score_reg;
        dir_next      = dir_reg;
        winner_next   = winner_reg;
        count_next    = count_reg;
        recentre_next = 1'b0;

        case (state_reg)
            S_IDLE, S_OVER: begin
                if (start_edge) begin
                    score_next    = '0;
                    winner_next   = 2'b00;
                    count_next    = SERVE_COUNT;
                    recentre_next = 1'b1;
                    state_next    = S_SERVE;
                end
            end
            S_SERVE: begin
                if (count_reg == 8'd0) begin
                    state_next = S_PLAY;
                end else if (Tick) begin
                    count_next = count_reg - 8'd1;
                end
            end
            S_PLAY: begin
                case ({Goal2, Goal1})
                    2'b11: begin
                        // A let: nobody scores, but the ball is re-served.
                        count_next    = SERVE_COUNT;
                        recentre_next = 1'b1;
                        state_next    = S_SERVE;
                    end
                    2'b01: begin
                        score_next[0] = score_inc[0];
                        dir_next      = 1'b1;
                        if (score_hit[0]) begin
                            winner_next = 2'b01;
                            state_next  = S_OVER;
                        end else begin
                            count_next    = SERVE_COUNT;
                            recentre_next = 1'b1;
                            state_next    = S_SERVE;
                        end
                    end
                    2'b10: begin
                        score_next[1] = score_inc[1];
                        dir_next      = 1'b0;
                        if (score_hit[1]) begin
                            winner_next = 2'b10;
                            state_next  = S_OVER;
                        end else begin
                            count_next    = SERVE_COUNT;
                            recentre_next = 1'b1;
                            state_next    = S_SERVE;
                        end
                    end
                    default: begin
                        if (start_edge) begin
                            state_next = S_PAUSE;
                        end
                    end
                endcase
            end
            S_PAUSE: begin
                if (start_edge) begin
                    state_next = S_PLAY;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        enable_next = (state_next == S_PLAY);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg    <= S_IDLE;
            score_reg    <= '0;
            enable_reg   <= 1'b0;
            recentre_reg <= 1'b0;
            dir_reg      <= 1'b0;
            winner_reg   <= 2'b00;
            count_reg    <= 8'd0;
            // Reset high so a button held through reset yields no start edge.
            start_q_reg  <= 1'b1;
        end else begin
            state_reg    <= state_next;
            score_reg    <= score_next;
            enable_reg   <= enable_next;
            recentre_reg <= recentre_next;
            dir_reg      <= dir_next;
            winner_reg   <= winner_next;
            count_reg    <= count_next;
            start_q_reg  <= Start;
        end
    end

    assign Score1       = score_reg[0];
    assign Score2       = score_reg[1];
    assign BallEnable   = enable_reg;
    assign BallRecentre = recentre_reg;
    assign ServeDir     = dir_reg;
    assign Winner       = winner_reg;
    assign State        = state_reg;

endmodule
